// File: rtl/ppc_fetch_queue_pkg.sv
// ppc_fetch_queue_pkg: instruction/entry types shared by the fetch queue and its buffer.
// The predecode constants and helper exist only when PPC_FETCH_PREDECODE_EN is defined.
package ppc_fetch_queue_pkg;
    typedef logic [0:31] inst_t;
    typedef struct packed {
        inst_t       inst;
        logic [0:63] pc;
`ifdef PPC_FETCH_PREDECODE_EN
        logic        is_branch;
`endif
    } fetch_entry_t;
`ifdef PPC_FETCH_PREDECODE_EN
    localparam logic [0:5] OP_B     = 6'd18;
    localparam logic [0:5] OP_BC    = 6'd16;
    localparam logic [0:5] OP_XL    = 6'd19;
    localparam logic [0:9] XOP_BCLR = 10'd16;
    function automatic logic is_branch(input inst_t i);
        return i[0:5] == OP_B || i[0:5] == OP_BC || (i[0:5] == OP_XL && i[21:30] == XOP_BCLR);
    endfunction
`endif
endpackage

// File: rtl/ppc_fetch_queue_fifo.sv
// ppc_fetch_queue_fifo: DEPTH-entry instruction buffer, up to two writes and one read per cycle.
// Head is read straight from registered storage; flush empties it synchronously.
module ppc_fetch_queue_fifo
    import ppc_fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_wr0,
    input  logic          i_wr1,
    input  fetch_entry_t  i_d0,
    input  fetch_entry_t  i_d1,
    input  logic          i_rd,
    output fetch_entry_t  o_head,
    output logic          o_valid,
    output logic [CW-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);
    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_cnt;
    logic          w_rd;
    logic [1:0]    w_nwr;

    assign w_rd    = i_rd && r_cnt != '0;
    assign w_nwr   = {1'b0, i_wr0} + {1'b0, i_wr1};
    assign o_head  = r_mem[r_rd];
    assign o_valid = r_cnt != '0;
    assign o_count = r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_wr0)
                r_mem[r_wr] <= i_d0;
            if (i_wr1)
                r_mem[r_wr + PW'(1)] <= i_d1;
            r_rd  <= r_rd + PW'(w_rd);
            r_wr  <= r_wr + PW'(w_nwr);
            r_cnt <= r_cnt + CW'(w_nwr) - CW'(w_rd);
        end
    end

    // The issuer reserves space, so a write into a full buffer is a design bug.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush) begin
            assert (int'(r_cnt) + int'(w_nwr) - int'(w_rd) <= DEPTH);
            assert (!i_wr1 || i_wr0);
        end
    end
endmodule

// File: rtl/ppc_fetch_queue.sv
// ppc_fetch_queue: decoupled PPC fetch front end issuing doubleword reads and queueing big-endian words.
// Define PPC_FETCH_PREDECODE_EN to add the o_inst_is_branch predecode output.
module ppc_fetch_queue
    import ppc_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [0:63] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [0:60] o_req_addr,
    input  logic        i_rsp_valid,
    input  logic [0:63] i_rsp_data,
    input  logic        i_redirect,
    input  logic [0:63] i_redirect_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [0:31] o_inst,
    output logic [0:63] o_inst_pc
`ifdef PPC_FETCH_PREDECODE_EN
    ,
    output logic        o_inst_is_branch
`endif
);
    localparam int OW = $clog2(MAX_OUT + 1) + 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [0:63]   r_fetch_pc;
    logic [0:63]   r_rsp_pc;
    logic [OW-1:0] r_out;
    logic [OW-1:0] r_disc;
    logic [CW-1:0] w_count;
    logic          w_room;
    logic          w_acc;
    logic          w_keep;
    logic          w_pop;
    fetch_entry_t  w_d0;
    fetch_entry_t  w_d1;
    fetch_entry_t  w_head;

    // Every outstanding request may return two words; reserve both slots up front.
    assign w_room      = DEPTH - int'(w_count) - 2 * int'(r_out) >= 2;
    assign o_req_valid = !rst && !i_redirect && int'(r_out) < MAX_OUT && w_room;
    assign o_req_addr  = r_fetch_pc[0:60];
    assign w_acc       = o_req_valid && i_req_ready;
    assign w_keep      = i_rsp_valid && !i_redirect && r_disc == '0;
    assign w_pop       = o_inst_valid && i_inst_ready;
    assign o_inst      = w_head.inst;
    assign o_inst_pc   = w_head.pc;
`ifdef PPC_FETCH_PREDECODE_EN
    assign o_inst_is_branch = o_inst_valid && w_head.is_branch;
`endif

    always_comb begin
        w_d0      = '0;
        w_d1      = '0;
        w_d0.inst = r_rsp_pc[61] ? i_rsp_data[32:63] : i_rsp_data[0:31];
        w_d0.pc   = r_rsp_pc;
        w_d1.inst = i_rsp_data[32:63];
        w_d1.pc   = r_rsp_pc + 64'd4;
`ifdef PPC_FETCH_PREDECODE_EN
        w_d0.is_branch = is_branch(w_d0.inst);
        w_d1.is_branch = is_branch(w_d1.inst);
`endif
    end

    ppc_fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_redirect),
        .i_wr0   (w_keep),
        .i_wr1   (w_keep && !r_rsp_pc[61]),
        .i_d0    (w_d0),
        .i_d1    (w_d1),
        .i_rd    (w_pop),
        .o_head  (w_head),
        .o_valid (o_inst_valid),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_out      <= '0;
            r_disc     <= '0;
        end else if (i_redirect) begin
            r_fetch_pc <= {i_redirect_pc[0:61], 2'b00};
            r_rsp_pc   <= {i_redirect_pc[0:61], 2'b00};
            r_out      <= '0;
            // Whatever is still in flight (less a response landing now) must be discarded.
            r_disc     <= r_disc + r_out - OW'(i_rsp_valid);
        end else begin
            if (w_acc)
                r_fetch_pc <= r_fetch_pc + (r_fetch_pc[61] ? 64'd4 : 64'd8);
            if (w_keep)
                r_rsp_pc <= r_rsp_pc + (r_rsp_pc[61] ? 64'd4 : 64'd8);
            r_out  <= r_out + OW'(w_acc) - OW'(w_keep);
            r_disc <= r_disc - OW'(i_rsp_valid && r_disc != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(r_out) <= MAX_OUT);
            assert (int'(r_disc) + int'(r_out) < 2 ** OW);
        end
    end
endmodule

// File: tb/tb_ppc_fetch_queue.sv
// tb_ppc_fetch_queue: directed and random stimulus against a queue-of-pcs model with an epoch-tagged memory.
// Define PPC_FETCH_PREDECODE_EN to also exercise the predecode output.
module tb_ppc_fetch_queue;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    typedef struct {
        logic [63:0] pc;
        logic [60:0] addr;
        int          epoch;
        int          due;
    } req_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        want_rst = 1;
    logic        req_valid;
    logic        req_ready = 0;
    logic [60:0] req_addr;
    logic        rsp_valid = 0;
    logic [63:0] rsp_data = '0;
    logic        redirect = 0;
    logic [63:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
`ifdef PPC_FETCH_PREDECODE_EN
    logic        inst_is_branch;
    logic        s_br;
    logic        popped_br[$];
`endif

    always #5 clk = ~clk;

    ppc_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(64'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .o_req_valid   (req_valid),
        .i_req_ready   (req_ready),
        .o_req_addr    (req_addr),
        .i_rsp_valid   (rsp_valid),
        .i_rsp_data    (rsp_data),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_inst_valid  (inst_valid),
        .i_inst_ready  (inst_ready),
        .o_inst        (inst),
        .o_inst_pc     (inst_pc)
`ifdef PPC_FETCH_PREDECODE_EN
        ,
        .o_inst_is_branch (inst_is_branch)
`endif
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          m_out = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [63:0] m_fetch = '0;
    logic [63:0] q[$];
    req_t        pend[$];
    logic [60:0] accs[$];
    logic [63:0] popped[$];
    logic [31:0] popped_inst[$];
    logic        s_req_valid;
    logic [60:0] s_req_addr;
    logic        s_inst_valid;
    logic [31:0] s_inst;
    logic [63:0] s_inst_pc;

    function automatic logic [31:0] memword(input logic [63:0] p);
        case (p)
            64'h200: return 32'h48000010;
            64'h204: return 32'h7C221A14;
            64'h208: return 32'h4E800020;
            64'h20C: return 32'h60000000;
            default: return {p[15:0], ~p[15:0]};
        endcase
    endfunction

`ifdef PPC_FETCH_PREDECODE_EN
    function automatic logic exp_br(input logic [31:0] w);
        int op, xop;
        op  = int'(w >> 26);
        xop = int'((w >> 1) & 32'h3FF);
        return op == 18 || op == 16 || (op == 19 && xop == 16);
    endfunction
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, compare against the model, advance the model at posedge.
    task automatic tick(input logic rr, input logic ir, input logic rd, input logic [63:0] rp);
        logic        rv;
        logic [63:0] base;
        req_t        h;
        int          lat;
        @(negedge clk);
        rst = want_rst;
        rv = pend.size() > 0 && pend[0].due <= cyc;
        base = rv ? {pend[0].addr, 3'b000} : '0;
        rsp_valid = rv;
        rsp_data = rv ? {memword(base), memword(base + 64'd4)} : '0;
        req_ready = rr;
        inst_ready = ir;
        redirect = rd;
        redirect_pc = rp;
        #1;
        s_req_valid = req_valid;
        s_req_addr = req_addr;
        s_inst_valid = inst_valid;
        s_inst = inst;
        s_inst_pc = inst_pc;
`ifdef PPC_FETCH_PREDECODE_EN
        s_br = inst_is_branch;
`endif
        if (!rst) begin
            chk("req_valid", 64'(s_req_valid),
                64'(!rd && m_out < MAX_OUT && DEPTH - q.size() - 2 * m_out >= 2));
            if (s_req_valid)
                chk("req_addr", 64'(s_req_addr), m_fetch >> 3);
            chk("inst_valid", 64'(s_inst_valid), 64'(q.size() > 0));
            chk("occupancy", 64'(q.size() <= DEPTH), 64'd1);
            if (s_inst_valid && q.size() > 0) begin
                chk("inst_pc", s_inst_pc, q[0]);
                chk("inst", 64'(s_inst), 64'(memword(q[0])));
`ifdef PPC_FETCH_PREDECODE_EN
                chk("inst_is_branch", 64'(s_br), 64'(exp_br(memword(q[0]))));
`endif
            end
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            pend.delete();
            m_out = 0;
            m_fetch = '0;
            epoch++;
        end else begin
            if (s_inst_valid && ir && q.size() > 0) begin
                popped.push_back(q.pop_front());
                popped_inst.push_back(s_inst);
`ifdef PPC_FETCH_PREDECODE_EN
                popped_br.push_back(s_br);
`endif
            end
            if (rv) begin
                h = pend.pop_front();
                if (h.epoch == epoch && !rd) begin
                    q.push_back(h.pc);
                    if (!h.pc[2])
                        q.push_back(h.pc + 64'd4);
                    m_out--;
                end
            end
            if (rd) begin
                q.delete();
                epoch++;
                m_fetch = rp & ~64'h3;
                m_out = 0;
            end
            if (s_req_valid && rr) begin
                lat = $urandom_range(lat_max, lat_min);
                pend.push_back('{pc: m_fetch, addr: s_req_addr, epoch: epoch, due: cyc + lat});
                accs.push_back(s_req_addr);
                m_fetch = (m_fetch & ~64'h7) + 64'd8;
                m_out++;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        want_rst = 1;
        tick(0, 0, 0, '0);
        tick(0, 0, 0, '0);
        chk("rst_req_valid", 64'(s_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(s_inst_valid), 64'd0);
        want_rst = 0;
    endtask

    task automatic clear_logs();
        accs.delete();
        popped.delete();
        popped_inst.delete();
`ifdef PPC_FETCH_PREDECODE_EN
        popped_br.delete();
`endif
    endtask

    initial begin
        int   gaps;
        bit   started;
        bit   hit;
        logic [63:0] pc0;
        logic [31:0] in0;

        // Streaming at latency 1 from reset
        do_reset();
        clear_logs();
        gaps = 0;
        started = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1, 1, 0, '0);
            if (started && !s_inst_valid)
                gaps++;
            if (s_inst_valid)
                started = 1;
        end
        chk("t1_acc0", 64'(accs[0]), 64'h0);
        chk("t1_acc1", 64'(accs[1]), 64'h1);
        chk("t1_acc2", 64'(accs[2]), 64'h2);
        chk("t1_pc0", popped[0], 64'h0);
        chk("t1_pc1", popped[1], 64'h4);
        chk("t1_pc2", popped[2], 64'h8);
        chk("t1_pc3", popped[3], 64'hC);
        chk("t1_inst0", 64'(popped_inst[0]), 64'h0000FFFF);
        chk("t1_gaps", 64'(gaps), 64'd0);

        // Decode stalled: exactly two requests fill the queue
        do_reset();
        clear_logs();
        tick(1, 0, 0, '0);
        tick(1, 0, 0, '0);
        tick(1, 0, 0, '0);
        pc0 = s_inst_pc;
        in0 = s_inst;
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, 0, '0);
            chk("t2_hold_pc", s_inst_pc, pc0);
            chk("t2_hold_inst", 64'(s_inst), 64'(in0));
        end
        chk("t2_reqs", 64'(accs.size()), 64'd2);
        chk("t2_count", 64'(q.size()), 64'd4);
        chk("t2_req_valid", 64'(s_req_valid), 64'd0);
        chk("t2_head", s_inst_pc, 64'h0);
        for (int i = 0; i < 20; i++)
            tick(1, 1, 0, '0);
        chk("t2_res0", popped[0], 64'h0);
        chk("t2_res1", popped[1], 64'h4);
        chk("t2_res4", popped[4], 64'h10);

        // Redirect with two requests outstanding at latency 6
        lat_min = 6;
        lat_max = 6;
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (m_out == 2 && !(pend.size() > 0 && pend[0].due <= cyc)) begin
                tick(1, 1, 1, 64'h104);
                hit = 1;
            end else
                tick(1, 1, 0, '0);
        end
        chk("t3_trigger", 64'(hit), 64'd1);
        clear_logs();
        for (int i = 0; i < 40; i++)
            tick(1, 1, 0, '0);
        chk("t3_addr", 64'(accs[0]), 64'h20);
        chk("t3_pc0", popped[0], 64'h104);
        chk("t3_inst0", 64'(popped_inst[0]), 64'h0104FEFB);
        chk("t3_pc1", popped[1], 64'h108);

        // Redirect colliding with a response and a pop
        lat_min = 2;
        lat_max = 2;
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (q.size() > 0 && pend.size() > 0 && pend[0].due <= cyc) begin
                clear_logs();
                tick(1, 1, 1, 64'h300);
                chk("t4_no_req", 64'(s_req_valid), 64'd0);
                chk("t4_popped", 64'(popped.size()), 64'd1);
                hit = 1;
            end else
                tick(1, 1, 0, '0);
        end
        chk("t4_trigger", 64'(hit), 64'd1);
        tick(1, 1, 0, '0);
        chk("t4_flushed", 64'(s_inst_valid), 64'd0);
        for (int i = 0; i < 20; i++)
            tick(1, 1, 0, '0);
        chk("t4_next", popped[1], 64'h300);

`ifdef PPC_FETCH_PREDECODE_EN
        // Predecode of b / add / blr
        lat_min = 1;
        lat_max = 1;
        tick(1, 1, 1, 64'h200);
        clear_logs();
        for (int i = 0; i < 12; i++)
            tick(1, 1, 0, '0);
        chk("t6_br0", 64'(popped_br[0]), 64'd1);
        chk("t6_br1", 64'(popped_br[1]), 64'd0);
        chk("t6_br2", 64'(popped_br[2]), 64'd1);
`endif

        // Random latency, backpressure and redirects
        lat_min = 1;
        lat_max = 6;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 199) == 0)
                tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1,
                     $urandom_range(0, 4) == 0 ? 64'hFFFF_FFFF_FFFF_FFF6 : 64'($urandom_range(0, 65535)));
            else
                tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
